b12_stim_player: RTL and testbench

B12_STIM_PLAYER -- requirements
Module: b12_stim_player

---
 rtl/b12_stim_player.sv | 82 ++++++++
 tb/tb_b12_stim_player.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/b12_stim_player.sv
// b12_stim_player: plays a stored opcode program onto the game-core obs/k/start inputs, one opcode per cycle.
module b12_stim_player (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [5:0] wr_data,
    input  logic       run,
    input  logic [6:0] len,
    input  logic       abort,
    output logic       obs,
    output logic [3:0] k,
    output logic       start,
    output logic [6:0] pc,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    state_t state, state_n;
    logic [5:0] mem [0:100];
    logic [5:0] op, op_n;
    logic [6:0] pc_n, len_q, len_n, pc_nx;
    assign pc_nx = pc + 7'd1;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op    <= '0;
            pc    <= '0;
            len_q <= '0;
        end else begin
            state <= state_n;
            op    <= op_n;
            pc    <= pc_n;
            len_q <= len_n;
        end
    end
    always_ff @(posedge clock)
        if (!reset && wr_en && wr_addr <= 7'd100 && state != PLAY)
            mem[wr_addr] <= wr_data;
    always_comb begin
        state_n = state;
        op_n    = op;
        pc_n    = pc;
        len_n   = len_q;
        if (abort) begin
            state_n = IDLE;
            op_n    = '0;
            pc_n    = '0;
        end else begin
            case (state)
                IDLE: if (run) begin
                    if (len == 7'd0) begin
                        state_n = DONE;
                    end else begin
                        state_n = PLAY;
                        len_n   = len > 7'd100 ? 7'd101 : len;
                        pc_n    = '0;
                        // a same-edge write to address 0 must reach the first presented opcode
                        op_n    = (wr_en && wr_addr == 7'd0) ? wr_data : mem[0];
                    end
                end
                PLAY: if (pc == len_q - 7'd1) begin
                    state_n = DONE;
                    op_n    = '0;
                end else begin
                    pc_n = pc_nx;
                    op_n = mem[pc_nx];
                end
                DONE: if (!run) begin
                    state_n = IDLE;
                    pc_n    = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    assign obs   = op[5];
    assign k     = op[4:1];
    assign start = op[0];
    assign busy  = state == PLAY;
    assign done  = state == DONE;
endmodule

// File: tb/tb_b12_stim_player.sv
// tb_b12_stim_player: directed-vector bench for the opcode stimulus player.
module tb_b12_stim_player;
    logic clock = 0, reset = 1, wr_en = 0, run = 0, abort = 0;
    logic [6:0] wr_addr = 0, len = 0;
    logic [5:0] wr_data = 0;
    logic obs, start, busy, done;
    logic [3:0] k;
    logic [6:0] pc;
    int checks = 0, failures = 0;

    b12_stim_player dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .run(run), .len(len), .abort(abort), .obs(obs), .k(k), .start(start),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [5:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    function automatic logic [5:0] f(input int i);
        return 6'((i * 7 + 3) % 64);
    endfunction

    function automatic logic [5:0] opv();
        return {obs, k, start};
    endfunction

    task automatic idle_chk(input string tag);
        check({tag, "_op"}, opv(), 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int nbusy;
        tick(); tick();
        idle_chk("reset");
        reset = 0;
        // basic four-opcode program
        wr(0, 6'b000011); wr(1, 6'b100100); wr(2, 6'b011110); wr(3, 6'b000001);
        len = 4; run = 1; tick(); run = 0;
        check("p0_obs", obs, 0); check("p0_k", k, 1); check("p0_start", start, 1);
        check("p0_pc", pc, 0); check("p0_busy", busy, 1);
        tick();
        check("p1_obs", obs, 1); check("p1_k", k, 2); check("p1_start", start, 0); check("p1_pc", pc, 1);
        tick();
        check("p2_obs", obs, 0); check("p2_k", k, 15); check("p2_start", start, 0); check("p2_pc", pc, 2);
        tick();
        check("p3_obs", obs, 0); check("p3_k", k, 0); check("p3_start", start, 1); check("p3_pc", pc, 3);
        tick();
        check("p_done", done, 1); check("p_done_busy", busy, 0);
        check("p_done_op", opv(), 0); check("p_done_pc", pc, 3);
        tick();
        idle_chk("p_idle");
        // zero length goes straight to DONE
        len = 0; run = 1; tick();
        check("z_done", done, 1); check("z_busy", busy, 0); check("z_op", opv(), 0); check("z_pc", pc, 0);
        run = 0; tick();
        idle_chk("z_idle");
        // full store, length clamped to 101
        for (int i = 0; i <= 100; i++) wr(7'(i), f(i));
        len = 127; run = 1; tick(); run = 0;
        nbusy = 0;
        for (int i = 0; i <= 100; i++) begin
            check("full_pc", pc, i);
            check("full_op", opv(), f(i));
            nbusy += busy;
            tick();
        end
        check("full_cycles", nbusy, 101);
        check("full_done", done, 1); check("full_end_pc", pc, 100); check("full_end_op", opv(), 0);
        tick();
        idle_chk("full_idle");
        // abort mid-play, then out-of-range write
        len = 10; run = 1; tick(); run = 0;
        tick(); tick();
        check("ab_pc2", pc, 2); check("ab_op2", opv(), f(2));
        abort = 1; tick(); abort = 0;
        idle_chk("ab_idle");
        wr(101, 6'h3F);
        wr(127, 6'h3F);
        len = 3; run = 1; tick(); run = 0;
        for (int i = 0; i < 3; i++) begin
            check("oor_op", opv(), f(i));
            tick();
        end
        check("oor_done", done, 1);
        tick();
        // write to address 0 on the launch edge is visible immediately
        wr_en = 1; wr_addr = 0; wr_data = 6'h2A; len = 2; run = 1; tick();
        wr_en = 0; run = 0;
        check("byp_op0", opv(), 6'h2A); check("byp_pc0", pc, 0);
        tick();
        check("byp_op1", opv(), f(1));
        tick(); tick();
        // reset mid-play, then relaunch
        len = 10; run = 1; tick(); run = 0;
        repeat (5) tick();
        check("rst_pc5", pc, 5);
        reset = 1; tick(); reset = 0;
        idle_chk("rst_idle");
        len = 3; run = 1; tick(); run = 0;
        check("rst_re_pc", pc, 0); check("rst_re_busy", busy, 1); check("rst_re_op", opv(), 6'h2A);
        repeat (4) tick();
        // write during play ignored; run held and len changed after launch
        len = 4; run = 1; tick(); len = 1;
        tick();
        check("wp_pc1", pc, 1);
        wr(2, 6'h15);
        check("wp_pc2", pc, 2); check("wp_op2", opv(), f(2));
        tick();
        check("wp_pc3", pc, 3); check("wp_busy3", busy, 1);
        tick();
        check("wp_done", done, 1);
        tick();
        check("wp_hold", done, 1);
        run = 0; tick();
        check("wp_idle", done, 0);
        len = 3; run = 1; tick(); run = 0;
        tick(); tick();
        check("wp_re_op2", opv(), f(2));
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
